// File: rtl/rs_latch_arbiter.sv
// -----------------------------------------------------------------------------
// rs_latch_arbiter
//
// Purpose
//   Shares one NAND-style RS latch (active-low set/reset inputs) between N_REQ
//   requesters. Each requester asks to set or reset the latch. One requester
//   is picked round-robin. The block then drives a timed low pulse on s_n_o or
//   r_n_o, followed by a gap with both lines high. It keeps a shadow copy of
//   the latch Q and acks the winner with a one-cycle grant.
//
// Parameters
//   N_REQ      number of requesters (>= 2)
//   PULSE_CYC  cycles s_n_o / r_n_o is held low per operation (>= 1)
//   GAP_CYC    cycles both lines are held high after each pulse (>= 1)
//
// Ports
//   clk             in   1      clock, rising edge
//   rst_n           in   1      asynchronous reset, active low
//   set_req_i       in   N_REQ  per-requester set request (level, held until grant)
//   rst_req_i       in   N_REQ  per-requester reset request (level, held until grant)
//   grant_o         out  N_REQ  one-hot, one-cycle ack of the completed operation
//   s_n_o           out  1      latch set input, active low, idle 1
//   r_n_o           out  1      latch reset input, active low, idle 1
//   q_state_o       out  1      shadow of the latch Q (1 = set)
//   busy_o          out  1      1 whenever the FSM is not in IDLE
//   conflict_err_o  out  1      one-cycle pulse: in an IDLE cycle some requester
//                               had set and reset both high
//
// Handshake
//   A requester raises exactly one of set_req_i[i] / rst_req_i[i] and holds it
//   until it sees grant_o[i]; the request is dropped in the grant cycle. Both
//   high is not a request: it is flagged on conflict_err_o and never granted.
//   Requests are only looked at while the FSM is in IDLE.
//
// Configuration
//   SKIP_REDUNDANT_EN  when defined, an op that would leave the latch unchanged
//                      (set while Q=1, reset while Q=0) is granted one cycle
//                      after IDLE without any pulse and without a gap.
//
// All outputs come straight from flops.
// -----------------------------------------------------------------------------
module rs_latch_arbiter #(
   parameter int N_REQ     = 4,
   parameter int PULSE_CYC = 2,
   parameter int GAP_CYC   = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [N_REQ-1:0] set_req_i,
   input  logic [N_REQ-1:0] rst_req_i,
   output logic [N_REQ-1:0] grant_o,
   output logic             s_n_o,
   output logic             r_n_o,
   output logic             q_state_o,
   output logic             busy_o,
   output logic             conflict_err_o
);

   localparam int MAX_CYC = (PULSE_CYC > GAP_CYC) ? PULSE_CYC : GAP_CYC;
   localparam int CNT_W   = $clog2(MAX_CYC + 1);
   localparam int PTR_W   = (N_REQ > 1) ? $clog2(N_REQ) : 1;

   // ST_ACK is only reachable when SKIP_REDUNDANT_EN is defined.
   typedef enum logic [2:0] {
      ST_INIT  = 3'd0,
      ST_IDLE  = 3'd1,
      ST_PULSE = 3'd2,
      ST_GAP   = 3'd3,
      ST_ACK   = 3'd4
   } state_e;

   // --------------------------------------------------------------------------
   // State and output registers
   // --------------------------------------------------------------------------
   state_e             state_q,  state_d;
   logic [CNT_W-1:0]   cnt_q,    cnt_d;
   logic               op_q,     op_d;       // 1 = set, 0 = reset
   logic               init_q,   init_d;     // current pulse is the post-reset clear
   logic [PTR_W-1:0]   win_q,    win_d;
   logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
   logic [N_REQ-1:0]   grant_q,  grant_d;
   logic               s_n_q,    s_n_d;
   logic               r_n_q,    r_n_d;
   logic               q_q,      q_d;
   logic               busy_q,   busy_d;
   logic               conf_q,   conf_d;

   // --------------------------------------------------------------------------
   // Helpers
   // --------------------------------------------------------------------------
   function automatic logic [N_REQ-1:0] onehot(input logic [PTR_W-1:0] idx);
      logic [N_REQ-1:0] v;
      v = '0;
      v[idx] = 1'b1;
      return v;
   endfunction

   function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] idx);
      logic [PTR_W-1:0] n;
      if (idx == PTR_W'(N_REQ - 1)) n = '0;
      else                          n = idx + 1'b1;
      return n;
   endfunction

   // --------------------------------------------------------------------------
   // Request decode and round-robin search
   // --------------------------------------------------------------------------
   logic [N_REQ-1:0] req_valid;
   logic             conflict_any;
   logic             found;
   logic [PTR_W-1:0] win_idx;

   assign req_valid    = set_req_i ^ rst_req_i;
   assign conflict_any = |(set_req_i & rst_req_i);

   // Scan N_REQ slots starting at rr_ptr_q, wrapping at N_REQ-1 -> 0;
   // the first valid slot wins.
   always_comb begin
      int idx;
      found   = 1'b0;
      win_idx = '0;
      idx     = 0;
      for (int i = 0; i < N_REQ; i++) begin
         idx = int'(rr_ptr_q) + i;
         if (idx >= N_REQ) idx = idx - N_REQ;
         if (!found && req_valid[PTR_W'(idx)]) begin
            found   = 1'b1;
            win_idx = PTR_W'(idx);
         end
      end
   end

   // --------------------------------------------------------------------------
   // Next-state logic
   // --------------------------------------------------------------------------
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      op_d     = op_q;
      init_d   = init_q;
      win_d    = win_q;
      rr_ptr_d = rr_ptr_q;
      grant_d  = '0;
      q_d      = q_q;
      conf_d   = 1'b0;

      case (state_q)
         // Bring the physical latch to a known state (Q=0) after reset.
         ST_INIT: begin
            state_d = ST_PULSE;
            op_d    = 1'b0;
            init_d  = 1'b1;
            cnt_d   = CNT_W'(PULSE_CYC - 1);
         end

         ST_IDLE: begin
            conf_d = conflict_any;
            if (found) begin
               win_d  = win_idx;
               op_d   = set_req_i[win_idx];
               init_d = 1'b0;
`ifdef SKIP_REDUNDANT_EN
               if (set_req_i[win_idx] == q_q) begin
                  // Latch already holds the requested value: ack only.
                  state_d  = ST_ACK;
                  grant_d  = onehot(win_idx);
                  rr_ptr_d = next_ptr(win_idx);
               end else begin
                  state_d = ST_PULSE;
                  cnt_d   = CNT_W'(PULSE_CYC - 1);
               end
`else
               state_d = ST_PULSE;
               cnt_d   = CNT_W'(PULSE_CYC - 1);
`endif
            end
         end

         ST_PULSE: begin
            if (cnt_q == '0) begin
               // Pulse complete: the latch now holds op_q.
               state_d = ST_GAP;
               cnt_d   = CNT_W'(GAP_CYC - 1);
               q_d     = op_q;
               if (!init_q) begin
                  grant_d  = onehot(win_q);
                  rr_ptr_d = next_ptr(win_q);
               end
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end

         ST_GAP: begin
            if (cnt_q == '0) state_d = ST_IDLE;
            else             cnt_d   = cnt_q - 1'b1;
         end

         // Grant of a skipped op is in flight; the requester drops its
         // request this cycle, so IDLE sees it gone.
         ST_ACK: begin
            state_d = ST_IDLE;
         end

         default: begin
            state_d = ST_INIT;
         end
      endcase
   end

   // Outputs are derived from the next state so they are registered yet
   // aligned with the state they belong to. Only one of s_n/r_n can be low
   // because op_d selects exactly one line.
   always_comb begin
      s_n_d  = !((state_d == ST_PULSE) &&  op_d);
      r_n_d  = !((state_d == ST_PULSE) && !op_d);
      busy_d = (state_d != ST_IDLE);
   end

   // --------------------------------------------------------------------------
   // Registers
   // --------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_INIT;
         cnt_q    <= '0;
         op_q     <= 1'b0;
         init_q   <= 1'b1;
         win_q    <= '0;
         rr_ptr_q <= '0;
         grant_q  <= '0;
         s_n_q    <= 1'b1;
         r_n_q    <= 1'b1;
         q_q      <= 1'b0;
         busy_q   <= 1'b1;
         conf_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         op_q     <= op_d;
         init_q   <= init_d;
         win_q    <= win_d;
         rr_ptr_q <= rr_ptr_d;
         grant_q  <= grant_d;
         s_n_q    <= s_n_d;
         r_n_q    <= r_n_d;
         q_q      <= q_d;
         busy_q   <= busy_d;
         conf_q   <= conf_d;
      end
   end

   assign grant_o        = grant_q;
   assign s_n_o          = s_n_q;
   assign r_n_o          = r_n_q;
   assign q_state_o      = q_q;
   assign busy_o         = busy_q;
   assign conflict_err_o = conf_q;

endmodule
